// File: rtl/wb_result_port.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_port
// Purpose  : Buffered result-reporting port. Snoops register-file writeback,
//            captures writes that fall in the register window [REG_LO,REG_HI]
//            into a circular FIFO, and presents the head entry show-ahead on
//            a valid/ready interface. An almost-full stall request gives the
//            core room to absorb writebacks already in flight. Captures that
//            arrive while the FIFO is full are dropped; the next stored entry
//            carries tag 2'b01 so the consumer knows data was lost.
// Ports    : clock, reset (async, active-high), flush (sync FIFO clear)
//            write / write_reg / write_data       writeback snoop inputs
//            to_peripheral[1:0]                   head tag (00 ok, 01 lost)
//            to_peripheral_reg / _data            head register index / data
//            to_peripheral_valid / _ready         head handshake
//            stall_request                        almost-full back-pressure
//            fifo_level                           current occupancy
//            drop_count                           dropped-capture counter
// Config   : WB_RESULT_PORT_DROP_COUNT_EN  - when defined, builds a saturating
//            drop counter (cleared only by reset); otherwise drop_count = 0.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_LO      = 10,
  parameter int REG_HI      = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int ALMOST_FULL = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            write,
  input  logic [4:0]                      write_reg,
  input  logic [DATA_WIDTH-1:0]           write_data,
  output logic [1:0]                      to_peripheral,
  output logic [4:0]                      to_peripheral_reg,
  output logic [DATA_WIDTH-1:0]           to_peripheral_data,
  output logic                            to_peripheral_valid,
  input  logic                            to_peripheral_ready,
  output logic                            stall_request,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]            drop_count
);

  localparam int              c_AW     = $clog2(FIFO_DEPTH);
  localparam int              c_LW     = c_AW + 1;
  localparam logic [4:0]      c_REG_LO = REG_LO[4:0];
  localparam logic [4:0]      c_REG_HI = REG_HI[4:0];
  localparam logic [c_LW-1:0] c_DEPTH  = FIFO_DEPTH[c_LW-1:0];
  localparam logic [c_LW-1:0] c_AF     = ALMOST_FULL[c_LW-1:0];
  localparam logic [c_LW-1:0] c_ONE    = {{(c_LW-1){1'b0}}, 1'b1};

  // Storage: one lost bit, register index and data per entry.
  logic                  r_mem_lost [FIFO_DEPTH];
  logic [4:0]            r_mem_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];

  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_LW-1:0] r_level;
  logic            r_lost;

  logic w_cap;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_cap   = write && (write_reg >= c_REG_LO) && (write_reg <= c_REG_HI)
                   && (write_reg != 5'd0);
  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == c_DEPTH);
  // Flush overrides every same-cycle push, pop and drop.
  assign w_pop   = w_valid && to_peripheral_ready && !flush;
  assign w_push  = w_cap && (!w_full || (w_valid && to_peripheral_ready)) && !flush;
  assign w_drop  = w_cap && w_full && !to_peripheral_ready && !flush;

  // Pointers, level and sticky lost flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_lost   <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_lost   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + c_ONE;
      else if (w_pop && !w_push) r_level <= r_level - c_ONE;
      // Drop and accept are mutually exclusive, so the order here is safe.
      if (w_drop)      r_lost <= 1'b1;
      else if (w_push) r_lost <= 1'b0;
    end
  end

  // Entry storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_lost[r_wr_ptr] <= r_lost;
      r_mem_reg[r_wr_ptr]  <= write_reg;
      r_mem_data[r_wr_ptr] <= write_data;
    end
  end

  assign to_peripheral_valid = w_valid;
  assign to_peripheral       = w_valid ? {1'b0, r_mem_lost[r_rd_ptr]} : 2'b00;
  assign to_peripheral_reg   = w_valid ? r_mem_reg[r_rd_ptr]  : 5'd0;
  assign to_peripheral_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign fifo_level          = r_level;
  // Decoded purely from the registered level; no input-to-output path.
  assign stall_request       = ((c_DEPTH - r_level) <= c_AF);

`ifdef WB_RESULT_PORT_DROP_COUNT_EN
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule
`default_nettype wire
